// File: rtl/io_cmd_sequencer.sv
// Switch/button front end that assembles a read or write command and runs the MemoryControl handshake.
// Optional feature: define IO_AUTO_INC_EN to let commit in DONE re-issue the command at the next word address.
module io_cmd_sequencer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 64,
  parameter int SW_W    = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        button,
  input  logic [SW_W-1:0]   sw,
  input  logic              memCmdDoneIn,
  input  logic [DATA_W-1:0] memDataIn,
  output logic [1:0]        memCmd,
  output logic [DATA_W-1:0] ioDataOut,
  output logic [ADDR_W-1:0] memAddrOut,
  output logic              ioCmdDoneOut,
  output logic [DATA_W-1:0] dispData,
  output logic              err
);

  localparam int A_NIB   = ADDR_W / SW_W;
  localparam int D_NIB   = DATA_W / SW_W;
  localparam int MAX_NIB = (A_NIB > D_NIB) ? A_NIB : D_NIB;
  localparam int CNT_W   = $clog2(MAX_NIB + 1);
  localparam int TMO_W   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam int WIDE    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t              state_q;
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_sh_q;
  logic [DATA_W-1:0]   data_sh_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [1:0]          mem_cmd_q;
  logic [ADDR_W-1:0]   addr_out_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                io_done_q;
  logic [DATA_W-1:0]   disp_q;
  logic                err_q;

  logic [ADDR_W-1:0]   addr_shift_d;
  logic [DATA_W-1:0]   data_shift_d;
  logic [WIDE-1:0]     addr_wide_d;
  logic [CNT_W-1:0]    cnt_inc_d;
  logic                enter_d, commit_d, abort_d;
  logic                addr_exit_d, data_exit_d, tmo_hit_d;
  logic [ADDR_W-1:0]   addr_final_d;
  logic [DATA_W-1:0]   data_final_d;

  assign enter_d      = (button == 2'b01);
  assign commit_d     = (button == 2'b10);
  assign abort_d      = (button == 2'b11);
  assign addr_shift_d = {addr_sh_q[ADDR_W-SW_W-1:0], sw};
  assign data_shift_d = {data_sh_q[DATA_W-SW_W-1:0], sw};
  assign addr_wide_d  = WIDE'(addr_shift_d);
  assign cnt_inc_d    = cnt_q + 1'b1;
  // The last nibble both shifts and exits, so the exit value must include it.
  assign addr_exit_d  = commit_d || (enter_d && cnt_inc_d == CNT_W'(A_NIB));
  assign data_exit_d  = commit_d || (enter_d && cnt_inc_d == CNT_W'(D_NIB));
  assign addr_final_d = enter_d ? addr_shift_d : addr_sh_q;
  assign data_final_d = enter_d ? data_shift_d : data_sh_q;
  assign tmo_hit_d    = (tmo_q == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      mem_cmd_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      io_done_q  <= 1'b0;
      disp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (button[0] && (sw[1:0] == CMD_RD || sw[1:0] == CMD_WR)) begin
            cmd_q     <= sw[1:0];
            addr_sh_q <= '0;
            cnt_q     <= '0;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (abort_d) begin
            state_q <= S_IDLE;
          end else begin
            if (enter_d) begin
              addr_sh_q <= addr_shift_d;
              cnt_q     <= cnt_inc_d;
              disp_q    <= addr_wide_d[DATA_W-1:0];
            end
            if (addr_exit_d) begin
              if (cmd_q == CMD_WR) begin
                data_sh_q <= '0;
                cnt_q     <= '0;
                state_q   <= S_DATA;
              end else begin
                mem_cmd_q  <= cmd_q;
                addr_out_q <= addr_final_d;
                data_out_q <= '0;
                io_done_q  <= 1'b1;
                tmo_q      <= '0;
                state_q    <= S_REQ;
              end
            end
          end
        end
        S_DATA: begin
          if (abort_d) begin
            state_q <= S_IDLE;
          end else begin
            if (enter_d) begin
              data_sh_q <= data_shift_d;
              cnt_q     <= cnt_inc_d;
              disp_q    <= data_shift_d;
            end
            if (data_exit_d) begin
              mem_cmd_q  <= cmd_q;
              addr_out_q <= addr_sh_q;
              data_out_q <= data_final_d;
              io_done_q  <= 1'b1;
              tmo_q      <= '0;
              state_q    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (!memCmdDoneIn) begin
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end else if (tmo_hit_d) begin
            mem_cmd_q <= '0;
            io_done_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (memCmdDoneIn) begin
            mem_cmd_q <= '0;
            io_done_q <= 1'b0;
            disp_q    <= (cmd_q == CMD_RD) ? memDataIn : data_out_q;
            state_q   <= S_DONE;
          end else if (tmo_hit_d) begin
            mem_cmd_q <= '0;
            io_done_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DONE: begin
          if (button[0]) begin
            state_q <= S_IDLE;
          end
`ifdef IO_AUTO_INC_EN
          else if (button[1]) begin
            addr_out_q <= addr_out_q + ADDR_W'(DATA_W / 8);
            mem_cmd_q  <= cmd_q;
            io_done_q  <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_REQ;
          end
`endif
        end
        S_ERR: begin
          if (button[1]) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign memCmd       = mem_cmd_q;
  assign memAddrOut   = addr_out_q;
  assign ioDataOut    = data_out_q;
  assign ioCmdDoneOut = io_done_q;
  assign dispData     = disp_q;
  assign err          = err_q;

endmodule

// File: tb/tb_io_cmd_sequencer.sv
// Scoreboard bench for io_cmd_sequencer: expected requests are queued as commands are keyed in
// and checked when the DUT issues and completes them against a small MemoryControl model.
module tb_io_cmd_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 64;
  localparam int SW_W   = 4;
  localparam int TMO    = 16;

  logic              clk;
  logic              rst_n;
  logic [1:0]        button;
  logic [SW_W-1:0]   sw;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic [1:0]        memCmd;
  logic [DATA_W-1:0] ioDataOut;
  logic [ADDR_W-1:0] memAddrOut;
  logic              ioCmdDoneOut;
  logic [DATA_W-1:0] dispData;
  logic              err;

  io_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SW_W(SW_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .sw(sw),
    .memCmdDoneIn(mem_done), .memDataIn(mem_data),
    .memCmd(memCmd), .ioDataOut(ioDataOut), .memAddrOut(memAddrOut),
    .ioCmdDoneOut(ioCmdDoneOut), .dispData(dispData), .err(err)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [31:0] disp;
    bit          exp_err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode     = 0;   // 0: busy for 2 cycles, 1: never accepts, 2: accepts and stays busy
  int   busy_cnt = 0;
  bit   served   = 0;
  bit   mon_en   = 1;
  logic [1:0] prev_cmd  = '0;
  logic       prev_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic press(input logic [1:0] b, input logic [SW_W-1:0] s);
    @(negedge clk);
    button = b;
    sw     = s;
    @(negedge clk);
    button = 2'b00;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] c, input logic [63:0] a, input logic [31:0] w,
                      input logic [31:0] d, input bit e);
    exp_t x;
    x.cmd = c; x.addr = a; x.wdata = w; x.disp = d; x.exp_err = e;
    sb_q.push_back(x);
  endtask

  // MemoryControl model, driven away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mode == 0) begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) mem_done = 1'b1;
        end else if (memCmd != 2'b00 && mem_done && !served) begin
          mem_done = 1'b0;
          busy_cnt = 2;
          served   = 1;
        end
        if (memCmd == 2'b00) served = 0;
      end else if (mode == 2) begin
        if (memCmd != 2'b00) mem_done = 1'b0;
      end
    end
  end

  // Issue and completion monitor.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_cmd == 2'b00 && memCmd != 2'b00) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_spurious_issue", 64'(memCmd), 64'd0);
        end else begin
          check_eq("issue_cmd", 64'(memCmd), 64'(sb_q[0].cmd));
          check_eq("issue_addr", memAddrOut, sb_q[0].addr);
          check_eq("issue_wdata", 64'(ioDataOut), 64'(sb_q[0].wdata));
          check_eq("issue_cmd_done_out", 64'(ioCmdDoneOut), 64'd1);
        end
      end
      if (prev_done && !ioCmdDoneOut) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_spurious_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.exp_err) check_eq("timeout_err", 64'(err), 64'd1);
          else               check_eq("result_disp", 64'(dispData), 64'(mon_e.disp));
          check_eq("cmd_dropped", 64'(memCmd), 64'd0);
        end
      end
    end
    prev_cmd  = memCmd;
    prev_done = ioCmdDoneOut;
  end

  initial begin
    int cyc;
    rst_n    = 1'b0;
    button   = 2'b00;
    sw       = '0;
    mem_done = 1'b1;
    mem_data = 32'hDEADBEEF;
    wait_cyc(2);
    check_eq("rst_memcmd", 64'(memCmd), 64'd0);
    check_eq("rst_disp", 64'(dispData), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Reset while the request is outstanding.
    mode = 2;
    press(2'b01, 4'h1);
    press(2'b01, 4'h9);
    push(2'b01, 64'h9, 32'h0, 32'h0, 1'b0);
    press(2'b10, 4'h0);
    wait_cyc(4);
    check_eq("wait_holds_cmd", 64'(memCmd), 64'd1);
    mon_en = 0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_memcmd", 64'(memCmd), 64'd0);
    check_eq("async_rst_cmddone", 64'(ioCmdDoneOut), 64'd0);
    check_eq("async_rst_disp", 64'(dispData), 64'd0);
    sb_q.delete();
    mode     = 0;
    mem_done = 1'b1;
    rst_n    = 1'b1;
    wait_cyc(2);
    mon_en = 1;

    // Read at 0x123.
    press(2'b01, 4'h1);
    press(2'b01, 4'h1);
    press(2'b01, 4'h2);
    press(2'b01, 4'h3);
    check_eq("addr_echo", 64'(dispData), 64'h123);
    push(2'b01, 64'h123, 32'h0, 32'hDEADBEEF, 1'b0);
    press(2'b10, 4'h0);
    wait_cyc(10);
    check_eq("sb_drain_read", 64'(sb_q.size()), 64'd0);
    press(2'b01, 4'h0);

    // Write with a full-length address that exits on its own.
    press(2'b01, 4'h2);
    for (int i = 0; i < ADDR_W / SW_W; i++) press(2'b01, 4'hF);
    press(2'b01, 4'hA);
    press(2'b01, 4'h5);
    check_eq("data_echo", 64'(dispData), 64'hA5);
    push(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 32'hA5, 32'hA5, 1'b0);
    press(2'b10, 4'h0);
    wait_cyc(10);
    check_eq("sb_drain_write", 64'(sb_q.size()), 64'd0);

    // Commit in DONE.
`ifdef IO_AUTO_INC_EN
    push(2'b10, 64'h3, 32'hA5, 32'hA5, 1'b0);
    press(2'b10, 4'h0);
    wait_cyc(10);
    check_eq("sb_drain_autoinc", 64'(sb_q.size()), 64'd0);
`else
    press(2'b10, 4'h0);
    wait_cyc(5);
    check_eq("no_autoinc_cmd", 64'(memCmd), 64'd0);
    check_eq("no_autoinc_disp", 64'(dispData), 64'hA5);
`endif
    press(2'b01, 4'h0);

    // Timeout: the model never accepts.
    mode = 1;
    press(2'b01, 4'h1);
    press(2'b01, 4'h5);
    push(2'b01, 64'h5, 32'h0, 32'h0, 1'b1);
    press(2'b10, 4'h0);
    cyc = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      if (err) break;
      if (memCmd != 2'b00) cyc++;
      @(negedge clk);
    end
    check_eq("timeout_reached", 64'(err), 64'd1);
    check_eq("timeout_cycles", 64'(cyc), 64'(TMO));
    check_eq("timeout_memcmd", 64'(memCmd), 64'd0);
    press(2'b10, 4'h0);
    check_eq("err_cleared", 64'(err), 64'd0);
    check_eq("sb_drain_timeout", 64'(sb_q.size()), 64'd0);
    mode = 0;

    // Abort after three address nibbles, then an invalid command code.
    press(2'b01, 4'h1);
    press(2'b01, 4'h1);
    press(2'b01, 4'h2);
    press(2'b01, 4'h3);
    press(2'b11, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_cmd", 64'(memCmd), 64'd0);
    end
    press(2'b01, 4'h3);
    press(2'b01, 4'h1);
    press(2'b01, 4'h7);
    push(2'b01, 64'h7, 32'h0, 32'hDEADBEEF, 1'b0);
    press(2'b10, 4'h0);
    wait_cyc(10);
    check_eq("sb_drain_after_abort", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
